// File: rtl/halflife_pkg.sv
// Shared types and default sizing for the half-life decay block.
package halflife_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEF    = 4;
    localparam int W_DEF    = 8;
    localparam int HMAX_DEF = 15;

endpackage

// File: rtl/halflife_edge.sv
// Detects a half-life boundary: the first cycle cnt equals period while running.
module halflife_edge
    import halflife_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_cnt,
    input  logic [N-1:0] i_period,
    input  logic         i_run,
    output logic         o_boundary
);

    logic w_match;
    logic r_prev_match;

    assign w_match = (i_cnt == i_period);

    // Registered every cycle, so a match already present when start is
    // accepted is seen as "previous" in the first RUN cycle and not counted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev_match <= 1'b0;
        end else begin
            r_prev_match <= w_match;
        end
    end

    assign o_boundary = i_run && w_match && !r_prev_match;

endmodule

// File: rtl/halflife_decay.sv
// Halves an amount on each timer half-life boundary and reports each halving
// on a one-deep valid/ready event channel with a sticky drop flag.
module halflife_decay
    import halflife_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int W    = W_DEF,
    parameter int HMAX = HMAX_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] cnt,
    input  logic [N-1:0] period,
    input  logic         start,
    input  logic [W-1:0] amt_in,
    input  logic         evt_ready,
    output logic [W-1:0] amount,
    output logic [3:0]   halvings,
    output logic         busy,
    output logic         done,
    output logic         evt_valid,
    output logic [W-1:0] evt_amount,
    output logic         ovf
);

    localparam logic [3:0] HMAX4 = 4'(HMAX);

    state_t       r_state;
    state_t       w_next_state;
    logic [W-1:0] r_amount;
    logic [3:0]   r_halvings;
    logic         r_evt_valid;
    logic [W-1:0] r_evt_amount;
    logic         r_ovf;

    logic         w_accept;
    logic         w_boundary;
    logic [W-1:0] w_new_amount;
    logic [3:0]   w_new_halvings;

    halflife_edge #(.N(N)) u_edge (
        .clk        (clk),
        .rst        (rst),
        .i_cnt      (cnt),
        .i_period   (period),
        .i_run      (r_state == RUN),
        .o_boundary (w_boundary)
    );

    always_comb begin
        w_accept       = start && (r_state != RUN);
        w_new_amount   = r_amount >> 1;
        w_new_halvings = r_halvings + 4'd1;
        w_next_state   = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next_state = (amt_in == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_boundary && ((w_new_amount == '0) || (w_new_halvings == HMAX4))) begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Boundaries only occur in RUN, so DONE naturally holds the datapath
    // while still letting a pending event drain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_amount     <= '0;
            r_halvings   <= '0;
            r_evt_valid  <= 1'b0;
            r_evt_amount <= '0;
            r_ovf        <= 1'b0;
        end else if (w_accept) begin
            r_amount    <= amt_in;
            r_halvings  <= '0;
            r_evt_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_boundary) begin
            r_amount   <= w_new_amount;
            r_halvings <= w_new_halvings;
            if (!r_evt_valid || evt_ready) begin
                r_evt_amount <= w_new_amount;
                r_evt_valid  <= 1'b1;
            end else begin
                r_ovf <= 1'b1;
            end
        end else if (r_evt_valid && evt_ready) begin
            r_evt_valid <= 1'b0;
        end
    end

    assign amount     = r_amount;
    assign halvings   = r_halvings;
    assign busy       = (r_state == RUN);
    assign done       = (r_state == DONE);
    assign evt_valid  = r_evt_valid;
    assign evt_amount = r_evt_amount;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_halflife_decay.sv
// Directed table-driven bench for halflife_decay plus long-run corner sequences.
module tb_halflife_decay;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] cnt = '0;
    logic [3:0] period = 4'd5;
    logic       start = 1'b0;
    logic [7:0] amt_in = '0;
    logic [15:0] amt16 = '0;
    logic       evt_ready = 1'b1;

    logic [7:0] amount, evt_amount;
    logic [3:0] halvings;
    logic       busy, done, evt_valid, ovf;

    logic [7:0] h3_amount, h3_evt_amount;
    logic [3:0] h3_halvings;
    logic       h3_busy, h3_done, h3_evt_valid, h3_ovf;

    logic [15:0] w16_amount, w16_evt_amount;
    logic [3:0]  w16_halvings;
    logic        w16_busy, w16_done, w16_evt_valid, w16_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    halflife_decay u_dut (
        .clk(clk), .rst(rst), .cnt(cnt), .period(period), .start(start),
        .amt_in(amt_in), .evt_ready(evt_ready), .amount(amount),
        .halvings(halvings), .busy(busy), .done(done), .evt_valid(evt_valid),
        .evt_amount(evt_amount), .ovf(ovf)
    );

    halflife_decay #(.HMAX(3)) u_h3 (
        .clk(clk), .rst(rst), .cnt(cnt), .period(period), .start(start),
        .amt_in(amt_in), .evt_ready(evt_ready), .amount(h3_amount),
        .halvings(h3_halvings), .busy(h3_busy), .done(h3_done),
        .evt_valid(h3_evt_valid), .evt_amount(h3_evt_amount), .ovf(h3_ovf)
    );

    halflife_decay #(.W(16)) u_w16 (
        .clk(clk), .rst(rst), .cnt(cnt), .period(period), .start(start),
        .amt_in(amt16), .evt_ready(evt_ready), .amount(w16_amount),
        .halvings(w16_halvings), .busy(w16_busy), .done(w16_done),
        .evt_valid(w16_evt_valid), .evt_amount(w16_evt_amount), .ovf(w16_ovf)
    );

    // Expected layout: {amount, halvings, busy, done, evt_valid, evt_amount, ovf}
    typedef struct packed {
        logic        rst;
        logic        start;
        logic [7:0]  amt;
        logic [3:0]  cnt;
        logic [3:0]  per;
        logic        rdy;
        logic [23:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [23:0] exp_q[$];

    function automatic logic [23:0] pk(input logic [7:0] a, input logic [3:0] h,
                                       input logic b, input logic d, input logic ev,
                                       input logic [7:0] ea, input logic o);
        return {a, h, b, d, ev, ea, o};
    endfunction

    task automatic add(input logic r, input logic s, input logic [7:0] a,
                       input logic [3:0] c, input logic [3:0] p, input logic rd,
                       input logic [23:0] e);
        vec_t v;
        v = '{rst: r, start: s, amt: a, cnt: c, per: p, rdy: rd, exp: e};
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic [7:0] a,
                         input logic [15:0] a16, input logic [3:0] c, input logic rd);
        @(negedge clk);
        rst = r; start = s; amt_in = a; amt16 = a16; cnt = c; evt_ready = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [23:0] e;
        logic [23:0] act;
        logic [7:0]  tail_amt[4];

        // Reset and basic ramp with ready consumer
        add(0,0,8'h00,0,5,1, pk(8'h00,0,0,0,0,8'h00,0));
        add(1,1,8'hC8,0,5,1, pk(8'hC8,0,1,0,0,8'h00,0));
        for (int c = 1; c <= 4; c++) add(1,0,8'h00,4'(c),5,1, pk(8'hC8,0,1,0,0,8'h00,0));
        add(1,0,8'h00,5,5,1, pk(8'h64,1,1,0,1,8'h64,0));
        add(1,0,8'h00,6,5,1, pk(8'h64,1,1,0,0,8'h64,0));
        add(1,0,8'h00,7,5,1, pk(8'h64,1,1,0,0,8'h64,0));
        add(1,0,8'h00,5,5,1, pk(8'h32,2,1,0,1,8'h32,0));
        // Mid-run reset at amount 0x32
        add(0,0,8'h00,0,5,1, pk(8'h00,0,0,0,0,8'h00,0));
        // Pre-existing match at start is not a boundary
        add(1,1,8'hC8,5,5,1, pk(8'hC8,0,1,0,0,8'h00,0));
        for (int k = 0; k < 4; k++) add(1,0,8'h00,5,5,1, pk(8'hC8,0,1,0,0,8'h00,0));
        add(1,0,8'h00,4,5,1, pk(8'hC8,0,1,0,0,8'h00,0));
        add(1,0,8'h00,5,5,1, pk(8'h64,1,1,0,1,8'h64,0));
        add(1,0,8'h00,5,5,1, pk(8'h64,1,1,0,0,8'h64,0));
        add(1,1,8'h10,5,5,1, pk(8'h64,1,1,0,0,8'h64,0));
        // Amount 1 reaches zero on the first boundary; later boundaries ignored
        add(0,0,8'h00,0,5,1, pk(8'h00,0,0,0,0,8'h00,0));
        add(1,1,8'h01,0,5,1, pk(8'h01,0,1,0,0,8'h00,0));
        add(1,0,8'h00,5,5,1, pk(8'h00,1,0,1,1,8'h00,0));
        add(1,0,8'h00,0,5,1, pk(8'h00,1,0,1,0,8'h00,0));
        add(1,0,8'h00,5,5,1, pk(8'h00,1,0,1,0,8'h00,0));
        add(1,1,8'h00,0,5,1, pk(8'h00,0,0,1,0,8'h00,0));
        // Stalled consumer drops the second event and sets ovf
        add(1,1,8'hC8,0,5,0, pk(8'hC8,0,1,0,0,8'h00,0));
        add(1,0,8'h00,5,5,0, pk(8'h64,1,1,0,1,8'h64,0));
        add(1,0,8'h00,0,5,0, pk(8'h64,1,1,0,1,8'h64,0));
        add(1,0,8'h00,5,5,0, pk(8'h32,2,1,0,1,8'h64,1));
        add(1,0,8'h00,0,5,0, pk(8'h32,2,1,0,1,8'h64,1));
        add(1,0,8'h00,5,5,1, pk(8'h19,3,1,0,1,8'h19,1));
        add(1,0,8'h00,0,5,1, pk(8'h19,3,1,0,0,8'h19,1));
        tail_amt = '{8'h0C, 8'h06, 8'h03, 8'h01};
        for (int k = 0; k < 4; k++) begin
            add(1,0,8'h00,5,5,1, pk(tail_amt[k],4'(4+k),1,0,1,tail_amt[k],1));
            add(1,0,8'h00,0,5,1, pk(tail_amt[k],4'(4+k),1,0,0,tail_amt[k],1));
        end
        add(1,0,8'h00,5,5,1, pk(8'h00,8,0,1,1,8'h00,1));
        add(1,0,8'h00,0,5,1, pk(8'h00,8,0,1,0,8'h00,1));
        // Start from DONE clears ovf
        add(1,1,8'h40,0,5,1, pk(8'h40,0,1,0,0,8'h00,0));
        // Reset wins over start; start accepted right after reset
        add(0,1,8'h55,0,5,1, pk(8'h00,0,0,0,0,8'h00,0));
        add(1,1,8'h55,0,5,1, pk(8'h55,0,1,0,0,8'h00,0));
        // period == 0 is a legal boundary value
        add(1,0,8'h00,0,0,1, pk(8'h2A,1,1,0,1,8'h2A,0));
        add(1,0,8'h00,0,0,1, pk(8'h2A,1,1,0,0,8'h2A,0));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; start = tbl[i].start; amt_in = tbl[i].amt;
            cnt = tbl[i].cnt; period = tbl[i].per; evt_ready = tbl[i].rdy;
            exp_q.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            e   = exp_q.pop_front();
            act = {amount, halvings, busy, done, evt_valid, evt_amount, ovf};
            check($sformatf("row%0d", i), {8'h00, act}, {8'h00, e});
        end

        // Long runs: 0xFF empties after 8 halvings, HMAX=3 caps at 3,
        // and a 16-bit 0xFFFF shows the 15-halving cap with amount 1 left.
        period = 4'd5;
        drive(0, 0, 8'h00, 16'h0000, 0, 1);
        drive(1, 1, 8'hFF, 16'h0000, 0, 1);
        drive(0, 0, 8'h00, 16'h0000, 0, 1);
        drive(1, 1, 8'h80, 16'hFFFF, 0, 1);
        drive(1, 0, 8'h00, 16'h0000, 0, 1);
        for (int k = 0; k < 16; k++) begin
            drive(1, 0, 8'h00, 16'h0000, 5, 1);
            drive(1, 0, 8'h00, 16'h0000, 0, 1);
        end
        check("h3_amount",    {24'h0, h3_amount},    32'h10);
        check("h3_halvings",  {28'h0, h3_halvings},  32'd3);
        check("h3_done",      {31'h0, h3_done},      32'd1);
        check("w16_amount",   {16'h0, w16_amount},   32'h0001);
        check("w16_halvings", {28'h0, w16_halvings}, 32'd15);
        check("w16_done",     {31'h0, w16_done},     32'd1);

        // Main instance: separate 0xFF run, 16 boundaries offered
        drive(0, 0, 8'h00, 16'h0000, 0, 1);
        drive(1, 1, 8'hFF, 16'h0000, 0, 1);
        drive(1, 0, 8'h00, 16'h0000, 0, 1);
        for (int k = 0; k < 16; k++) begin
            drive(1, 0, 8'h00, 16'h0000, 5, 1);
            drive(1, 0, 8'h00, 16'h0000, 0, 1);
        end
        check("ff_amount",   {24'h0, amount},   32'h00);
        check("ff_halvings", {28'h0, halvings}, 32'd8);
        check("ff_done",     {31'h0, done},     32'd1);
        check("ff_busy",     {31'h0, busy},     32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
